// File: rtl/alu32_rr_sched.sv
// alu32_rr_sched -- 8-requester round-robin scheduler for the shared 32-bit
// 8:1 result mux (mx8_32bits) of the alu32 datapath.
//
// Each cycle it picks one requesting source, drives the mux selects
// {s2,s1,s0} = sel, and registers the chosen word into a valid/ready output
// stage. The winning requester gets a one-cycle, one-hot ack in the same
// cycle that its word is captured.
//
// Optional feature (macro ARB_LOCK_EN): adds the req_lock port and lets the
// last-acked source keep the grant for up to LOCK_MAX consecutive loads.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req[7:0]   in   request per source, bit i = mux input i (a=0 .. h=7)
//   a..h       in   WIDTH-bit source words feeding the mux
//   ack[7:0]   out  one-hot pulse: requester i's word captured this cycle
//   sel[2:0]   out  {s2,s1,s0}, combinational index of the current winner
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts the word
//   out_data   out  registered mux result
//   out_src    out  index of the source held in out_data
//   req_lock   in   per-source lock request (ARB_LOCK_EN builds only)
//
// Output handshake: a word transfers to the consumer on every rising edge
// where out_valid && out_ready. While out_valid && !out_ready the stage is
// frozen (out_data/out_src stable, no ack). A new word may load in the same
// edge as a transfer, so the stage sustains one word per cycle.

module mx8_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic        s2,
  input  logic        s1,
  input  logic        s0,
  output logic [31:0] y
);
  always_comb begin
    case ({s2, s1, s0})
      3'd0:    y = a;
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      3'd5:    y = f;
      3'd6:    y = g;
      default: y = h;
    endcase
  end
endmodule

module alu32_rr_sched #(
  parameter int WIDTH    = 32,
  parameter int PTR_INIT = 0,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [7:0]       ack,
  output logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_src
`ifdef ARB_LOCK_EN
  ,
  input  logic [7:0]       req_lock
`endif
);

  logic [2:0]       ptr;
  logic [2:0]       rr_idx;
  logic [2:0]       idx;
  logic [2:0]       win;
  logic             load;
  logic [WIDTH-1:0] mux_y;

  // Round-robin search: walk from pointer+7 down to pointer so the last
  // hit (the one closest to the pointer) wins. With no requests the
  // result defaults to the pointer itself.
  always_comb begin
    rr_idx = ptr;
    idx    = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) rr_idx = idx;
    end
  end

`ifdef ARB_LOCK_EN
  localparam int             CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]  LOCK_MAX_C = CW'(LOCK_MAX);

  logic [CW-1:0] lock_cnt;
  logic          have_last;  // out_src names a real past grant
  logic          lock_hit;

  // The last-acked source (out_src) keeps the grant while it still
  // requests with lock and has not used up its LOCK_MAX budget.
  assign lock_hit = have_last && req[out_src] && req_lock[out_src] &&
                    (lock_cnt < LOCK_MAX_C);
  assign win      = lock_hit ? out_src : rr_idx;

  // lock_cnt counts consecutive grants to out_src made with lock held.
  // Once it reaches LOCK_MAX the round-robin search runs; if that search
  // lands on the same source again the run restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt  <= '0;
      have_last <= 1'b0;
    end else if (load) begin
      have_last <= 1'b1;
      if (!req_lock[win])
        lock_cnt <= '0;
      else if (have_last && (win == out_src) && (lock_cnt < LOCK_MAX_C))
        lock_cnt <= lock_cnt + CW'(1);
      else
        lock_cnt <= CW'(1);
    end else if (!req_lock[out_src]) begin
      lock_cnt <= '0;
    end
  end
`else
  assign win = rr_idx;
`endif

  // reset_n gates load so no ack escapes while reset is held.
  assign load = reset_n && (!out_valid || out_ready) && (req != 8'd0);
  assign sel  = win;
  assign ack  = load ? (8'd1 << win) : 8'd0;

  mx8_32bits u_mux (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .e  (e),
    .f  (f),
    .g  (g),
    .h  (h),
    .s2 (sel[2]),
    .s1 (sel[1]),
    .s0 (sel[0]),
    .y  (mux_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= 3'(PTR_INIT);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'd0;
    end else if (load) begin
      ptr       <= win + 3'd1;
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= win;
    end else if (out_valid && out_ready) begin
      // Pop with nothing to refill: data and source are left as they were.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu32_rr_sched.sv
module tb_alu32_rr_sched;

  logic        clk;
  logic        reset_n;
  logic [7:0]  req;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [7:0]  ack;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_src;
`ifdef ARB_LOCK_EN
  logic [7:0]  req_lock;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_data;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic [7:0] ack;
    logic [2:0] sel;
    logic       valid;
    logic [2:0] src;
  } tv_t;

  tv_t tv[$];

  alu32_rr_sched #(
    .WIDTH    (32),
    .PTR_INIT (0),
    .LOCK_MAX (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef ARB_LOCK_EN
    ,
    .req_lock  (req_lock)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source i carries the nibble (i+1) replicated: a=0x11111111 .. h=0x88888888.
  function automatic logic [31:0] src_data(input logic [2:0] s);
    logic [3:0] nib;
    nib = 4'(s) + 4'd1;
    return {8{nib}};
  endfunction

  function automatic void add(input logic [7:0] r, input logic rdy,
                              input logic [7:0] ak, input logic [2:0] s,
                              input logic v, input logic [2:0] src);
    tv_t t;
    t.req = r; t.rdy = rdy; t.ack = ak; t.sel = s; t.valid = v; t.src = src;
    tv.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational ack/sel mid-cycle, then
  // check the registered stage just after the rising edge.
  task automatic step(input logic [7:0] r, input logic rdy,
                      input logic [7:0] e_ack, input logic [2:0] e_sel,
                      input logic e_valid, input logic [2:0] e_src,
                      input string name);
    req       = r;
    out_ready = rdy;
    #2;
    chk({name, "_ack"}, 32'(ack), 32'(e_ack));
    chk({name, "_sel"}, 32'(sel), 32'(e_sel));
    if (e_ack != 8'd0) exp_q.push_back(src_data(e_sel));
    @(posedge clk);
    #1;
    if (e_ack != 8'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb: scoreboard queue empty", name);
      end else begin
        last_data = exp_q.pop_front();
      end
    end
    chk({name, "_valid"}, 32'(out_valid), 32'(e_valid));
    chk({name, "_src"},   32'(out_src),   32'(e_src));
    chk({name, "_data"},  out_data,       last_data);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 8'd0;
    out_ready = 1'b1;
    exp_q.delete();
    last_data = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    a = 32'h11111111; b = 32'h22222222; c = 32'h33333333; d = 32'h44444444;
    e = 32'h55555555; f = 32'h66666666; g = 32'h77777777; h = 32'h88888888;
`ifdef ARB_LOCK_EN
    req_lock = 8'd0;
`endif

    // Idle after reset: nothing valid, sel sits on the pointer (0).
    for (int i = 0; i < 5; i++) add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0);
    // All requesting: two full rotations 0..7.
    for (int i = 0; i < 16; i++) begin
      logic [2:0] s;
      s = 3'(i % 8);
      add(8'hFF, 1'b1, 8'd1 << s, s, 1'b1, s);
    end
    // Grant 6 to park the pointer at 7, then wrap 7 -> 0 -> 7.
    add(8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 3'd6);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 3'd7);
    add(8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 3'd0);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 3'd7);
    // Load source 1, then hold it under backpressure while 2 waits.
    add(8'h02, 1'b1, 8'h02, 3'd1, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) add(8'h04, 1'b0, 8'h00, 3'd2, 1'b1, 3'd1);
    add(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 3'd2);
    // Pop without refill, idle, then load into an empty stage with ready low.
    add(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 3'd2);
    add(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 3'd2);
    add(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 3'd4);
    add(8'h10, 1'b0, 8'h00, 3'd4, 1'b1, 3'd4);
    add(8'hFF, 1'b0, 8'h00, 3'd5, 1'b1, 3'd4);

    do_reset();
    for (int i = 0; i < tv.size(); i++)
      step(tv[i].req, tv[i].rdy, tv[i].ack, tv[i].sel, tv[i].valid, tv[i].src,
           $sformatf("v%0d", i));

    // Asynchronous reset while a word is held (valid=1, pointer=5).
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_data",  out_data,       32'd0);
    chk("rst_async_src",   32'(out_src),   32'd0);
    chk("rst_async_ack",   32'(ack),       32'd0);
    exp_q.delete();
    last_data = 32'd0;
    req = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, "rst_idle");
    step(8'h30, 1'b1, 8'h10, 3'd4, 1'b1, 3'd4, "rst_first");
    step(8'h30, 1'b1, 8'h20, 3'd5, 1'b1, 3'd5, "rst_second");

`ifdef ARB_LOCK_EN
    begin
      logic [2:0] lock_seq[10];
      lock_seq = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
      do_reset();
      req_lock = 8'h04;
      for (int i = 0; i < 10; i++)
        step(8'h0C, 1'b1, 8'd1 << lock_seq[i], lock_seq[i], 1'b1, lock_seq[i],
             $sformatf("lock%0d", i));
      req_lock = 8'h00;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_rr_sched.md
Name: alu32_rr_sched

Overview:
- 8-requester round-robin scheduler that shares the 32-bit 8:1 result mux (mx8_32bits) in the alu32 datapath.
- Picks one requesting source per cycle and drives the mux selects s2/s1/s0.
- Registers the selected 32-bit word into a valid/ready output stage, and returns a one-hot ack to the winning requester.
- Sits between the ALU functional units (mux inputs a..h) and the ALU result consumer.

Parameters:
- WIDTH, 32, data width; must stay 32 to match mx8_32bits.
- PTR_INIT, 0, round-robin pointer value after reset (0..7).
- LOCK_MAX, 4, maximum consecutive grants to one requester; used only when ARB_LOCK_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  8  request per source; bit i corresponds to mux input i (a=0 .. h=7).
- a, b, c, d, e, f, g, h  input  32 each  source data words feeding the internal mx8_32bits instance.
- ack  output  8  one-hot, single-cycle pulse; requester i's word was captured this cycle.
- sel  output  3  {s2,s1,s0} driven to the mux; combinational index of the current winner.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  32  registered mux result.
- out_src  output  3  index of the source in out_data.
- req_lock  input  8  per-source lock request; present only with ARB_LOCK_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (reset_n).
- Reset values: out_valid=0, out_data=0, out_src=0, ack=0, pointer=PTR_INIT, lock counter=0. sel follows the combinational grant logic; with req=0 it equals the pointer.
- Grant: first i with req[i]=1, searching pointer, pointer+1, ... mod 8. Wrap is 7->0. sel = winner index.
- Load condition: load = (!out_valid || out_ready) && (req != 0).
- On load:
  - out_data <= mux(sel), out_src <= sel, out_valid <= 1.
  - ack[winner] = 1 in the same cycle (combinational from load; one ack bit max).
  - pointer <= winner + 1 mod 8.
- Pop without refill: if out_valid && out_ready && req==0, then out_valid <= 0. out_data and out_src hold their last value.
- Backpressure: while out_valid && !out_ready, no load and no ack. out_data, out_src and pointer stay stable.
- Latency: request seen at cycle N with the stage free -> ack at N, out_valid/out_data at N+1.
- Simultaneous pop and refill: out_ready=1 with a pending req means the new word loads in the same cycle (full throughput, 1 word/cycle).
- Fairness: with all 8 requesters continuously active, the grant order is PTR_INIT, +1, ... and each source is served exactly once per 8 loads.
- Requester protocol: a requester holds req and its data stable until it sees ack. Dropping req before ack is legal; that source is simply skipped.
- Reset mid-transfer: any pending out_valid is discarded immediately, the pointer returns to PTR_INIT, and no ack is issued.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds the req_lock port and a lock counter ($clog2(LOCK_MAX+1) bits).
  - If the last-acked source k has req[k] && req_lock[k] and the counter < LOCK_MAX, k wins regardless of the pointer.
  - Each consecutive locked grant increments the counter.
  - The counter clears on a grant to a different source, or when req_lock[k]=0.
  - At counter==LOCK_MAX the normal round-robin search from pointer (k+1) is forced. If k is the only requester, k still wins and the counter restarts at 1.
- Undefined: no req_lock port, no counter; pure round-robin.

Test Plan:
- Reset release, req=0, out_ready=1 for 5 cycles -> out_valid=0, ack=0, sel=0 throughout.
- req=8'hFF, distinct data (a=0x11111111 .. h=0x88888888), out_ready=1 for 16 cycles -> out_src sequence 0..7,0..7, out_data matches the source, one ack bit per cycle.
- req=8'h81, pointer=7 (after granting 6) -> grants 7 then 0 (wrap), then 7 again.
- Load a word, then out_ready=0 for 4 cycles with req=8'h04 -> out_data frozen, ack=0; the first cycle out_ready=1 gives ack=8'h04 and the new word on the next cycle.
- Assert reset_n=0 mid-stream with out_valid=1 -> out_valid=0 asynchronously; after release the first grant searches from PTR_INIT.
- ARB_LOCK_EN, LOCK_MAX=4, req=8'h0C, req_lock=8'h04 -> grant sequence 2,2,2,2,3,2,2,2,2,3.
